// File: rtl/seq_det_ctrl.sv
// Programmable overlapping Mealy pattern detector with match counter and sticky threshold irq.
// Latency: out is combinational from signal; match_cnt/irq/busy update on the match edge.
// Backpressure: cfg_ready is high only in IDLE. Optional idle timeout: SEQ_DET_TIMEOUT_EN.
module seq_det_ctrl #(
    parameter int PAT_W   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             signal,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    input  logic             irq_clr,
    output logic             busy
`ifdef SEQ_DET_TIMEOUT_EN
    ,
    output logic             tmo
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0]       LEN_MAX = 4'(PAT_W);
    localparam logic [3:0]       RST_LEN = (PAT_W < 4) ? LEN_MAX : 4'd4;
    localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(11);
    localparam logic [CNT_W-1:0] RST_THR = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (PAT_W < 1 || PAT_W > 15 || TIMEOUT < 1) begin : g_bad_param
            $error("seq_det_ctrl: parameter out of range");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       len_q, len_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [3:0]       seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic             busy_q, busy_d;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic             tmo_q, tmo_d;
`endif

    // Newest bit sits at index 0; the window lines up with pattern bit order.
    logic [PAT_W:0]   window;
    logic [PAT_W:0]   len_mask;
    logic [4:0]       seen_plus1;
    logic             seen_ok;
    logic             pat_hit;
    logic             match;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       len_clamped;

    assign window     = {hist_q, signal};
    assign seen_plus1 = {1'b0, seen_q} + 5'd1;
    assign seen_ok    = seen_plus1 >= {1'b0, len_q};

    always_comb begin
        len_mask = '0;
        for (int i = 0; i <= PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign pat_hit = ((window ^ {1'b0, pat_q}) & len_mask) == '0;
    assign match   = (state_q == S_ARMED) && !rst && seen_ok && pat_hit;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == 4'd0) begin
            len_clamped = 4'd1;
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        thresh_d = thresh_q;
        hist_d   = hist_q;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        irq_d    = irq_q;
`ifdef SEQ_DET_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        tmo_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    pat_d    = cfg_pattern;
                    len_d    = len_clamped;
                    thresh_d = cfg_thresh;
                end
                if (start) begin
                    state_d = S_ARMED;
                    hist_d  = '0;
                    seen_d  = 4'd0;
                    cnt_d   = '0;
`ifdef SEQ_DET_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            S_ARMED: begin
                hist_d = window[PAT_W-1:0];
                seen_d = (seen_q == LEN_MAX) ? seen_q : seen_q + 4'd1;
                if (match) begin
                    cnt_d = cnt_inc;
                end
`ifdef SEQ_DET_TIMEOUT_EN
                tcnt_d = match ? '0 : tcnt_q + 1'b1;
`endif
                // stop wins over a threshold hit in the same cycle
                if (stop) begin
                    state_d = S_IDLE;
                end else if (match && (thresh_q != '0) && (cnt_inc == thresh_q)) begin
                    state_d = S_DONE;
                    irq_d   = 1'b1;
                end
`ifdef SEQ_DET_TIMEOUT_EN
                else if (!match && (tcnt_q == TMO_W'(TIMEOUT - 1))) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (irq_clr) begin
                    state_d = S_IDLE;
                    irq_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pat_q    <= RST_PAT;
            len_q    <= RST_LEN;
            thresh_q <= RST_THR;
            hist_q   <= '0;
            seen_q   <= 4'd0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            tcnt_q   <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            thresh_q <= thresh_d;
            hist_q   <= hist_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
`ifdef SEQ_DET_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign out       = match;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;
    assign busy      = busy_q;
`ifdef SEQ_DET_TIMEOUT_EN
    assign tmo       = tmo_q;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomized and directed bench for seq_det_ctrl against a bit-history reference model.
module tb_seq_det_ctrl;

    localparam int PAT_W   = 8;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [3:0]       cfg_len = 4'd0;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             signal = 1'b0;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             irq;
    logic             irq_clr = 1'b0;
    logic             busy;
`ifdef SEQ_DET_TIMEOUT_EN
    logic             tmo;
`endif

    always #5 clk = ~clk;

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .start       (start),
        .stop        (stop),
        .signal      (signal),
        .out         (out),
        .match_cnt   (match_cnt),
        .irq         (irq),
        .irq_clr     (irq_clr),
        .busy        (busy)
`ifdef SEQ_DET_TIMEOUT_EN
        ,
        .tmo         (tmo)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain list of bits received since arming.
    bit             m_valid = 1'b0;
    bit             m_armed = 1'b0;
    bit             m_done  = 1'b0;
    bit             m_irq   = 1'b0;
    bit             m_tmo   = 1'b0;
    logic [7:0]     m_pat   = 8'h0B;
    logic [7:0]     m_thr   = 8'd1;
    int             m_len   = 4;
    int             m_cnt   = 0;
    int             m_tcnt  = 0;
    bit             m_hist[$];
    bit             exp_out = 1'b0;

    function automatic bit m_match(input bit sig);
        int n;
        bit b;
        if (!m_armed) return 1'b0;
        n = m_hist.size();
        if (n + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            b = (k == m_len - 1) ? sig : m_hist[n - (m_len - 1) + k];
            if (b != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_update();
        bit was_idle;
        bit mt;
        int l;
        if (rst) begin
            m_valid = 1'b1;
            m_armed = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_tmo = 1'b0;
            m_pat = 8'h0B; m_len = 4; m_thr = 8'd1; m_cnt = 0; m_tcnt = 0;
            m_hist.delete();
            return;
        end
        m_tmo = 1'b0;
        was_idle = !m_armed && !m_done;
        if (was_idle) begin
            if (cfg_valid) begin
                l = int'(cfg_len);
                if (l == 0) l = 1;
                else if (l > PAT_W) l = PAT_W;
                m_pat = cfg_pattern; m_len = l; m_thr = cfg_thresh;
            end
            if (start) begin
                m_armed = 1'b1; m_cnt = 0; m_tcnt = 0;
                m_hist.delete();
            end
        end else if (m_armed) begin
            mt = m_match(signal);
            m_hist.push_back(signal);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
            if (mt && m_cnt < 255) m_cnt++;
            if (stop) begin
                m_armed = 1'b0;
            end else if (mt && m_thr != 0 && m_cnt == int'(m_thr)) begin
                m_armed = 1'b0; m_done = 1'b1; m_irq = 1'b1;
            end
`ifdef SEQ_DET_TIMEOUT_EN
            else if (!mt && m_tcnt == TIMEOUT - 1) begin
                m_armed = 1'b0; m_tmo = 1'b1;
            end
`endif
            m_tcnt = mt ? 0 : m_tcnt + 1;
        end else begin
            if (irq_clr) begin
                m_done = 1'b0; m_irq = 1'b0;
            end
        end
    endtask

    // One clock: advance the model with the inputs the DUT just sampled, then drive new inputs.
    task automatic cyc(input bit r, input bit cv, input logic [7:0] cp, input logic [3:0] cl,
                       input logic [7:0] ct, input bit st, input bit sp, input bit sg, input bit ic);
        @(posedge clk);
        #1;
        m_update();
        rst = r; cfg_valid = cv; cfg_pattern = cp; cfg_len = cl; cfg_thresh = ct;
        start = st; stop = sp; signal = sg; irq_clr = ic;
        exp_out = !r && m_match(sg);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("out", 32'(out), 32'(exp_out));
            chk("cfg_ready", 32'(cfg_ready), 32'(!m_armed && !m_done));
            chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("busy", 32'(busy), 32'(m_armed || m_done));
`ifdef SEQ_DET_TIMEOUT_EN
            chk("tmo", 32'(tmo), 32'(m_tmo));
`endif
        end
    end

    task automatic bitin(input bit sg);
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, sg, 1'b0);
    endtask

    task automatic arm_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
        cyc(1'b0, 1'b1, p, l, t, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_stop();
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        bitin(1'b0);
    endtask

    // Streams n bits MSB-first; ov[i] records out during the (i+1)-th bit.
    task automatic stream(input logic [15:0] bits, input int n, output logic [15:0] ov);
        ov = '0;
        for (int i = 0; i < n; i++) begin
            bitin(bits[n - 1 - i]);
            ov[i] = out;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ov;
        logic [7:0]  cp;
        logic [3:0]  cl;
        logic [7:0]  ct;

        cyc(1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        bitin(1'b0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Default pattern 1011, thresh 1
        do_start();
        stream(16'b0101_1011, 8, ov);
        chk("t1_out_pulses", 32'(ov), 32'h0010);
        chk("t1_irq", 32'(irq), 32'd1);
        chk("t1_cnt", 32'(match_cnt), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        do_clr();
        chk("t1_clr_busy", 32'(busy), 32'd0);
        chk("t1_clr_irq", 32'(irq), 32'd0);
        chk("t1_cnt_kept", 32'(match_cnt), 32'd1);

        // Overlapping matches with thresh 3, config and start in the same cycle
        arm_cfg(8'h0B, 4'd4, 8'd3);
        stream(16'b10_1101_1011, 10, ov);
        chk("t2_out_pulses", 32'(ov), 32'h0248);
        bitin(1'b0);
        chk("t2_cnt", 32'(match_cnt), 32'd3);
        chk("t2_irq", 32'(irq), 32'd1);
        do_clr();

        // Config offered while armed waits until IDLE
        do_start();
        cyc(1'b0, 1'b1, 8'h06, 4'd4, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_ready_armed", 32'(cfg_ready), 32'd0);
        cyc(1'b0, 1'b1, 8'h06, 4'd4, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h06, 4'd4, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_ready_idle", 32'(cfg_ready), 32'd1);
        do_start();
        stream(16'b0110, 4, ov);
        chk("t3_out_pulses", 32'(ov), 32'h0008);
        bitin(1'b0);
        chk("t3_irq", 32'(irq), 32'd1);
        do_clr();

        // len 0 -> 1, thresh 0 never fires
        arm_cfg(8'h01, 4'd0, 8'd0);
        stream(16'b1011, 4, ov);
        chk("t4_out_pulses", 32'(ov), 32'h000D);
        bitin(1'b0);
        chk("t4_cnt", 32'(match_cnt), 32'd3);
        chk("t4_irq", 32'(irq), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        do_stop();
        // len 12 clamps to 8: match only once all 8 bits arrive
        arm_cfg(8'hCA, 4'd12, 8'd0);
        stream(16'b1100_1010, 8, ov);
        chk("t4_clamp_pulses", 32'(ov), 32'h0080);
        do_stop();

        // stop coinciding with the threshold match
        arm_cfg(8'h0B, 4'd4, 8'd1);
        stream(16'b101, 3, ov);
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_out", 32'(out), 32'd1);
        bitin(1'b0);
        chk("t5_cnt", 32'(match_cnt), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_irq", 32'(irq), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cp = 8'($urandom);
            cl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            ct = 8'($urandom_range(0, 4));
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), cp, cl, ct,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), 1'($urandom),
                ($urandom_range(0, 4) == 0));
        end
        bitin(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
